// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: result latencies and forward-select encoding.
package hzd_pkg;
  localparam int unsigned MAXLAT_DEF = 4;
  localparam int unsigned LAT_ALU    = 1;
  localparam int unsigned LAT_LOAD   = 2;
  localparam int unsigned LAT_MUL    = MAXLAT_DEF;
  localparam int unsigned FWD_RF     = 0;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage <-> scoreboard bundle; master is the decode stage, slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned LW   = 3,
  parameter int unsigned FW   = 2
);
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic          id_wreg;
  logic [AW-1:0] id_waddr;
  logic [LW-1:0] id_lat;
  logic          flush;
  logic          stall;
  logic          issue;
  logic [FW-1:0] fwda;
  logic [FW-1:0] fwdb;
  logic [NREG-1:0] busy;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_waddr, id_lat, flush,
    input  stall, issue, fwda, fwdb, busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_waddr, id_lat, flush,
    output stall, issue, fwda, fwdb, busy
  );
endinterface

// File: rtl/hazard_scoreboard_src_check.sv
// Per-source hazard check: RAW stall against the latency counters and forward-stage selection.
module hzd_src_check
  import hzd_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned LW     = 3,
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned FW     = 2
) (
  input  logic [AW-1:0]        src,
  input  logic                 used,
  input  logic [NREG*LW-1:0]   cnt_vec,
  input  logic [NSTAGE-1:0]    trk_valid,
  input  logic [NSTAGE*AW-1:0] trk_addr,
  output logic                 raw_stall,
  output logic [FW-1:0]        fwd
);
  logic live;

  always_comb begin
    raw_stall = 1'b0;
    fwd       = FW'(FWD_RF);
    live      = used && (src != '0) && (32'(src) < NREG);
    if (live) begin
      raw_stall = cnt_vec[32'(src)*LW +: LW] > LW'(1);
      // Walk oldest to youngest so the youngest matching stage wins.
      for (int unsigned k = NSTAGE; k >= 1; k--) begin
        if (trk_valid[k-1] && (trk_addr[(k-1)*AW +: AW] == src)) fwd = FW'(k);
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: latency counters, RAW/WAW stall, in-flight write tracker, forward select.
// Optional macro HZD_STALL_CNT_EN adds a free-running 32-bit stall cycle counter output.
module hazard_scoreboard
  import hzd_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned MAXLAT = LAT_MUL,
  parameter int unsigned NSTAGE = 3
) (
  input  logic clk,
  input  logic rst_n,
  hazard_scoreboard_if.slave bus
`ifdef HZD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  localparam int unsigned LW = $clog2(MAXLAT + 1);
  localparam int unsigned FW = $clog2(NSTAGE + 1);

  logic [LW-1:0]        cnt_q [NREG];
  logic [LW-1:0]        cnt_d [NREG];
  logic [NSTAGE-1:0]    trk_valid_q, trk_valid_d;
  logic [NSTAGE*AW-1:0] trk_addr_q, trk_addr_d;
  logic [NREG*LW-1:0]   cnt_vec;
  logic [NREG-1:0]      busy;
  logic [LW-1:0]        lat_eff;
  logic                 raw_a, raw_b, waw, hazard, stall, issue, wr_en;
  logic [FW-1:0]        fwda, fwdb;

  always_comb begin
    cnt_vec = '0;
    busy    = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_vec[r*LW +: LW] = cnt_q[r];
      busy[r]             = cnt_q[r] != '0;
    end
  end

  hzd_src_check #(.NREG(NREG), .AW(AW), .LW(LW), .NSTAGE(NSTAGE), .FW(FW)) u_src_a (
    .src(bus.id_rs), .used(bus.id_rs_used), .cnt_vec(cnt_vec),
    .trk_valid(trk_valid_q), .trk_addr(trk_addr_q), .raw_stall(raw_a), .fwd(fwda)
  );

  hzd_src_check #(.NREG(NREG), .AW(AW), .LW(LW), .NSTAGE(NSTAGE), .FW(FW)) u_src_b (
    .src(bus.id_rt), .used(bus.id_rt_used), .cnt_vec(cnt_vec),
    .trk_valid(trk_valid_q), .trk_addr(trk_addr_q), .raw_stall(raw_b), .fwd(fwdb)
  );

  always_comb begin
    lat_eff = (bus.id_lat == '0) ? LW'(LAT_ALU) : bus.id_lat;
    waw     = 1'b0;
    if (bus.id_wreg && (bus.id_waddr != '0) && (32'(bus.id_waddr) < NREG))
      waw = cnt_q[bus.id_waddr] > lat_eff;
    hazard = raw_a | raw_b | waw;
    // Flush squashes the decode slot, so it masks stall as well as issue.
    stall  = bus.id_valid & hazard & ~bus.flush;
    issue  = bus.id_valid & ~hazard & ~bus.flush;
    wr_en  = issue & bus.id_wreg & (bus.id_waddr != '0);

    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : '0;
      if (wr_en && (32'(bus.id_waddr) == r)) cnt_d[r] = lat_eff;
    end
    cnt_d[0] = '0;

    trk_valid_d          = '0;
    trk_addr_d           = '0;
    trk_valid_d[0]       = wr_en;
    trk_addr_d[0 +: AW]  = bus.id_waddr;
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      trk_valid_d[k]         = trk_valid_q[k-1];
      trk_addr_d[k*AW +: AW] = trk_addr_q[(k-1)*AW +: AW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
      trk_valid_q <= '0;
      trk_addr_q  <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      trk_valid_q <= trk_valid_d;
      trk_addr_q  <= trk_addr_d;
    end
  end

  assign bus.stall = stall;
  assign bus.issue = issue;
  assign bus.fwda  = fwda;
  assign bus.fwdb  = fwdb;
  assign bus.busy  = busy;

`ifdef HZD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb stall_cnt_d = stall_cnt_q + {31'd0, stall};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: absolute-time readiness model plus directed hand-computed checks.
module tb_hazard_scoreboard;
  import hzd_pkg::*;

  localparam int unsigned NREG   = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned MAXLAT = 4;
  localparam int unsigned NSTAGE = 3;
  localparam int unsigned LW     = 3;
  localparam int unsigned FW     = 2;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_scoreboard_if #(.NREG(NREG), .AW(AW), .LW(LW), .FW(FW)) bus ();

`ifdef HZD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .MAXLAT(MAXLAT), .NSTAGE(NSTAGE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef HZD_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each register remembers the absolute cycle at which its counter reaches zero;
  // the write history is indexed by the cycle in which the write issued.
  int ready_at [NREG] = '{default: 0};
  bit hv [64] = '{default: 1'b0};
  int ha [64] = '{default: 0};
  int cyc = 64;
  int unsigned m_stall_cnt = 0;

  function automatic int cnt_of(int r);
    if (r == 0) return 0;
    return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
  endfunction

  function automatic int fwd_of(int s, bit used);
    if (!used || s == 0) return 0;
    for (int k = 1; k <= int'(NSTAGE); k++) begin
      int idx;
      idx = (cyc - k) % 64;
      if (hv[idx] && ha[idx] == s) return k;
    end
    return 0;
  endfunction

  function automatic void eval(output bit st, output bit is, output int fa, output int fb);
    int  lat;
    bit  hz;
    lat = (int'(bus.id_lat) == 0) ? 1 : int'(bus.id_lat);
    hz  = (bus.id_rs_used && bus.id_rs != 0 && cnt_of(int'(bus.id_rs)) > 1) ||
          (bus.id_rt_used && bus.id_rt != 0 && cnt_of(int'(bus.id_rt)) > 1) ||
          (bus.id_wreg && bus.id_waddr != 0 && cnt_of(int'(bus.id_waddr)) > lat);
    st = bus.id_valid && hz && !bus.flush;
    is = bus.id_valid && !hz && !bus.flush;
    fa = fwd_of(int'(bus.id_rs), bus.id_rs_used);
    fb = fwd_of(int'(bus.id_rt), bus.id_rt_used);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NREG); r++) ready_at[r] = 0;
      for (int i = 0; i < 64; i++) hv[i] = 1'b0;
      m_stall_cnt = 0;
    end else begin
      bit st, is, w;
      int fa, fb, lat;
      eval(st, is, fa, fb);
      if (st) m_stall_cnt++;
      lat = (int'(bus.id_lat) == 0) ? 1 : int'(bus.id_lat);
      w = is && bus.id_wreg && bus.id_waddr != 0;
      hv[cyc % 64] = w;
      ha[cyc % 64] = int'(bus.id_waddr);
      if (w) ready_at[int'(bus.id_waddr)] = cyc + 1 + lat;
      cyc++;
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit st, is;
    int fa, fb;
    logic [NREG-1:0] eb;
    eval(st, is, fa, fb);
    for (int r = 0; r < int'(NREG); r++) eb[r] = cnt_of(r) != 0;
    check("model_stall", 64'(bus.stall), 64'(st));
    check("model_issue", 64'(bus.issue), 64'(is));
    check("model_fwda", 64'(bus.fwda), 64'(fa));
    check("model_fwdb", 64'(bus.fwdb), 64'(fb));
    check("model_busy", 64'(bus.busy), 64'(eb));
`ifdef HZD_STALL_CNT_EN
    check("model_stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
`endif
  end

  task automatic drv(bit v, int rs, bit rsu, int rt, bit rtu, bit w, int wa, int lat, bit fl);
    bus.id_valid   = v;
    bus.id_rs      = AW'(rs);
    bus.id_rs_used = rsu;
    bus.id_rt      = AW'(rt);
    bus.id_rt_used = rtu;
    bus.id_wreg    = w;
    bus.id_waddr   = AW'(wa);
    bus.id_lat     = LW'(lat);
    bus.flush      = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dchk(string name, bit st, bit is, int fa, int fb);
    @(negedge clk);
    check({name, "_stall"}, 64'(bus.stall), 64'(st));
    check({name, "_issue"}, 64'(bus.issue), 64'(is));
    check({name, "_fwda"}, 64'(bus.fwda), 64'(fa));
    check({name, "_fwdb"}, 64'(bus.fwdb), 64'(fb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    // Outputs during reset reflect inputs against a cleared scoreboard.
    drv(1, 3, 1, 5, 1, 1, 7, 4, 0);
    dchk("in_reset", 0, 1, 0, 0);
    check("in_reset_busy", 64'(bus.busy), 64'd0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // ALU producer feeds next-cycle consumer via stage 1.
    drv(1, 0, 0, 0, 0, 1, 3, LAT_ALU, 0);
    dchk("w_r3", 0, 1, 0, 0);
    tick();
    drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
    dchk("raw_alu", 0, 1, 1, 0);
    tick();
    idle();
    tick();

    // Load producer: one bubble, then forward from stage 2.
    drv(1, 0, 0, 0, 0, 1, 5, LAT_LOAD, 0);
    dchk("w_r5", 0, 1, 0, 0);
    tick();
    drv(1, 0, 0, 5, 1, 0, 0, 0, 0);
    dchk("load_stall", 1, 0, 0, 1);
    tick();
    dchk("load_fwd", 0, 1, 0, 2);
    tick();
    idle();
    tick();

    // WAW: lat-4 write then lat-1 write to r7 waits until cnt[7] <= 1.
    drv(1, 0, 0, 0, 0, 1, 7, 4, 0);
    dchk("w_r7", 0, 1, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 1, 7, 1, 0);
    for (int i = 0; i < 3; i++) begin
      dchk("waw_hold", 1, 0, 0, 0);
      tick();
    end
    dchk("waw_issue", 0, 1, 0, 0);
    check("waw_busy7_a", 64'(bus.busy[7]), 64'd1);
    tick();
    idle();
    @(negedge clk);
    check("waw_busy7_b", 64'(bus.busy[7]), 64'd1);
    tick();
    @(negedge clk);
    check("waw_busy7_c", 64'(bus.busy[7]), 64'd0);
    tick();

    // Latency 0 behaves as latency 1.
    drv(1, 0, 0, 0, 0, 1, 8, 0, 0);
    dchk("w_r8_lat0", 0, 1, 0, 0);
    tick();
    drv(1, 8, 1, 8, 1, 0, 0, 0, 0);
    dchk("lat0_use", 0, 1, 1, 1);
    tick();

    // Register 0 never becomes busy or forwards.
    drv(1, 0, 0, 0, 0, 1, 0, 4, 0);
    dchk("w_r0", 0, 1, 0, 0);
    tick();
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0);
    dchk("r0_use", 0, 1, 0, 0);
    check("r0_busy", 64'(bus.busy), 64'd0);
    tick();

    // Flush masks stall and leaves a bubble in stage 1.
    drv(1, 0, 0, 0, 0, 1, 10, 2, 0);
    dchk("w_r10", 0, 1, 0, 0);
    tick();
    drv(1, 10, 1, 0, 0, 0, 0, 0, 1);
    dchk("flush", 0, 0, 1, 0);
    tick();
    drv(1, 10, 1, 0, 0, 0, 0, 0, 0);
    dchk("post_flush", 0, 1, 2, 0);
    tick();

    // Unused sources never stall nor forward.
    drv(1, 0, 0, 0, 0, 1, 12, 4, 0);
    dchk("w_r12", 0, 1, 0, 0);
    tick();
    drv(1, 12, 0, 12, 0, 0, 0, 0, 0);
    dchk("unused_src", 0, 1, 0, 0);
    tick();

    // Mid-operation reset discards pending r9 write.
    drv(1, 0, 0, 0, 0, 1, 9, 3, 0);
    dchk("w_r9", 0, 1, 0, 0);
    tick();
    idle();
    @(negedge clk);
    check("pre_rst_busy9", 64'(bus.busy[9]), 64'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_busy", 64'(bus.busy), 64'd0);
    tick();
    rst_n = 1'b1;
    drv(1, 9, 1, 0, 0, 0, 0, 0, 0);
    dchk("post_rst_r9", 0, 1, 0, 0);
    tick();
    idle();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
